vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator. It is the successor to the fixed 12-bit VGA output block and sits between the pixel source (framebuffer or tile renderer) and the board VGA pins. The block issues pixel coordinate requests a configurable number of cycles ahead of the displayed pixel, which covers memory and renderer latency. It delays sync, data-enable and colour so that they reach the pins together, with programmable channel depth and sync polarity.

---
 rtl/vga_timing_gen.sv | 158 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- parametrised VGA raster timing generator.
//
// Issues pixel coordinate requests LAT cycles ahead of display. It delays
// hsync/vsync/de through a LAT-deep shift register so that they leave the
// output registers together with the colour captured for that pixel.
//
// Ports:
//   clk, rst              pixel clock; synchronous active-high reset
//   color                 {R,G,B} colour, sampled LAT cycles after its request
//   req_valid/req_x/req_y visible-pixel coordinate request (0 when idle)
//   vga_r/g/b             registered colour to the DAC
//   vga_hsync/vga_vsync   registered syncs, active level set by *_POL
//   vga_de                registered data enable, aligned with vga_r/g/b
//   frame_start           pulse when the counters are at (0,0)
//   line_start            pulse when h_cnt is 0, on every line
module vga_timing_gen #(
    parameter int unsigned WIDTH     = 640,
    parameter int unsigned HEIGHT    = 480,
    parameter int unsigned H_FPORCH  = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BPORCH  = 48,
    parameter int unsigned V_FPORCH  = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BPORCH  = 33,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0,
    parameter int unsigned CH_BITS   = 4,
    parameter int unsigned LAT       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3*CH_BITS-1:0]   color,
    output logic                   req_valid,
    output logic [15:0]            req_x,
    output logic [15:0]            req_y,
    output logic [CH_BITS-1:0]     vga_r,
    output logic [CH_BITS-1:0]     vga_g,
    output logic [CH_BITS-1:0]     vga_b,
    output logic                   vga_hsync,
    output logic                   vga_vsync,
    output logic                   vga_de,
    output logic                   frame_start,
    output logic                   line_start
);

    localparam int unsigned H_TOTAL = WIDTH + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int unsigned V_TOTAL = HEIGHT + V_FPORCH + V_SYNC + V_BPORCH;

    generate
        if (H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_total_check
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 65535");
        end
        if (LAT < 1) begin : g_lat_check
            $error("vga_timing_gen: LAT must be at least 1");
        end
    endgenerate

    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_VIS    = 16'(WIDTH);
    localparam logic [15:0] V_VIS    = 16'(HEIGHT);
    localparam logic [15:0] HS_START = 16'(WIDTH + H_FPORCH);
    localparam logic [15:0] HS_END   = 16'(WIDTH + H_FPORCH + H_SYNC);
    localparam logic [15:0] VS_START = 16'(HEIGHT + V_FPORCH);
    localparam logic [15:0] VS_END   = 16'(HEIGHT + V_FPORCH + V_SYNC);

    // ------------------------------------------------------------------
    // Counter stage
    // ------------------------------------------------------------------
    logic [15:0] h_cnt_q, h_cnt_d;
    logic [15:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 16'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Request stage and raw timing (combinational from the counters)
    // ------------------------------------------------------------------
    logic hs_act, vs_act, de_raw;

    always_comb begin
        de_raw      = !rst && (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hs_act      = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vs_act      = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        req_valid   = de_raw;
        req_x       = de_raw ? h_cnt_q : '0;
        req_y       = de_raw ? v_cnt_q : '0;
        frame_start = !rst && (h_cnt_q == '0) && (v_cnt_q == '0);
        line_start  = !rst && (h_cnt_q == '0);
    end

    // ------------------------------------------------------------------
    // Alignment pipeline: stage LAT-1 lines up with the colour that the
    // source returns for the request made LAT cycles earlier.
    // ------------------------------------------------------------------
    logic [LAT-1:0] hs_pipe_q, vs_pipe_q, de_pipe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_pipe_q <= '0;
            vs_pipe_q <= '0;
            de_pipe_q <= '0;
        end else begin
            hs_pipe_q[0] <= hs_act;
            vs_pipe_q[0] <= vs_act;
            de_pipe_q[0] <= de_raw;
            for (int unsigned i = 1; i < LAT; i++) begin
                hs_pipe_q[i] <= hs_pipe_q[i-1];
                vs_pipe_q[i] <= vs_pipe_q[i-1];
                de_pipe_q[i] <= de_pipe_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [3*CH_BITS-1:0] rgb_q;
    logic                 de_q, hsync_q, vsync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q   <= '0;
            de_q    <= 1'b0;
            hsync_q <= !HSYNC_POL;
            vsync_q <= !VSYNC_POL;
        end else begin
            de_q    <= de_pipe_q[LAT-1];
            rgb_q   <= de_pipe_q[LAT-1] ? color : '0;
            hsync_q <= hs_pipe_q[LAT-1] ? HSYNC_POL : !HSYNC_POL;
            vsync_q <= vs_pipe_q[LAT-1] ? VSYNC_POL : !VSYNC_POL;
        end
    end

    assign vga_r     = rgb_q[3*CH_BITS-1 -: CH_BITS];
    assign vga_g     = rgb_q[2*CH_BITS-1 -: CH_BITS];
    assign vga_b     = rgb_q[CH_BITS-1:0];
    assign vga_de    = de_q;
    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: two instances on a small raster
// (8x6 total, 4x3 visible). Instance A uses LAT=2, 4-bit channels and
// active-low syncs. Instance B uses LAT=1, 8-bit channels and active-high
// syncs. Expected values come from a per-cycle history of reset and colour,
// and from the raster position computed with plain arithmetic.
module tb_vga_timing_gen;

    localparam int N      = 900;
    localparam int HT     = 8;
    localparam int VT     = 6;
    localparam int FRAME  = HT * VT;
    localparam int RST_MID = 5 + 3 * FRAME + 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] color_a = '0;
    logic [23:0] color_b = '0;

    logic        rv_a, hs_a, vs_a, de_a, fs_a, ls_a;
    logic [15:0] rx_a, ry_a;
    logic [3:0]  r_a, g_a, b_a;
    logic        rv_b, hs_b, vs_b, de_b, fs_b, ls_b;
    logic [15:0] rx_b, ry_b;
    logic [7:0]  r_b, g_b, b_b;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .WIDTH(4), .HEIGHT(3),
        .H_FPORCH(1), .H_SYNC(2), .H_BPORCH(1),
        .V_FPORCH(1), .V_SYNC(1), .V_BPORCH(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .CH_BITS(4), .LAT(2)
    ) u_dut_a (
        .clk(clk), .rst(rst), .color(color_a),
        .req_valid(rv_a), .req_x(rx_a), .req_y(ry_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_de(de_a),
        .frame_start(fs_a), .line_start(ls_a)
    );

    vga_timing_gen #(
        .WIDTH(4), .HEIGHT(3),
        .H_FPORCH(1), .H_SYNC(2), .H_BPORCH(1),
        .V_FPORCH(1), .V_SYNC(1), .V_BPORCH(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .CH_BITS(8), .LAT(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .color(color_b),
        .req_valid(rv_b), .req_x(rx_b), .req_y(ry_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_de(de_b),
        .frame_start(fs_b), .line_start(ls_b)
    );

    bit          rst_h [N];
    int          pos_h [N];
    logic [23:0] col_h_a [N];
    logic [23:0] col_h_b [N];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Raster rules for position p counted from the (0,0) after reset release.
    function automatic bit vis(input int p);
        return ((p % HT) < 4) && (((p / HT) % VT) < 3);
    endfunction

    function automatic bit hs_win(input int p);
        return ((p % HT) == 5) || ((p % HT) == 6);
    endfunction

    function automatic bit vs_win(input int p);
        return ((p / HT) % VT) == 4;
    endfunction

    // Combinational request outputs for the current cycle.
    task automatic check_req(input string pfx, input logic rv, input logic [15:0] rx,
                             input logic [15:0] ry, input logic fs, input logic ls);
        bit v;
        int p;
        p = pos_h[cyc];
        v = !rst_h[cyc] && vis(p);
        check_eq({pfx, "_req_valid"}, 32'(rv), 32'(v));
        check_eq({pfx, "_req_x"}, 32'(rx), v ? 32'(p % HT) : 32'd0);
        check_eq({pfx, "_req_y"}, 32'(ry), v ? 32'((p / HT) % VT) : 32'd0);
        check_eq({pfx, "_frame_start"}, 32'(fs), 32'(!rst_h[cyc] && (p % FRAME) == 0));
        check_eq({pfx, "_line_start"}, 32'(ls), 32'(!rst_h[cyc] && (p % HT) == 0));
    endtask

    // Registered pins: they show the counter state from lat+1 cycles ago and
    // the colour driven one cycle ago, unless a reset fell in that window.
    task automatic check_pins(input string pfx, input int lat, input bit pol,
                              input logic [23:0] rgb, input logic de,
                              input logic hs, input logic vs, input bit use_b);
        bit          ok;
        bit          e_de;
        int          p;
        logic [23:0] e_rgb;
        ok = (cyc - 1 - lat) >= 0;
        if (ok) begin
            for (int j = cyc - 1 - lat; j <= cyc - 1; j++) begin
                if (rst_h[j]) ok = 1'b0;
            end
        end
        p     = ok ? pos_h[cyc - 1 - lat] : 0;
        e_de  = ok && vis(p);
        e_rgb = '0;
        if (e_de) e_rgb = use_b ? col_h_b[cyc - 1] : col_h_a[cyc - 1];
        check_eq({pfx, "_rgb"}, 32'(rgb), 32'(e_rgb));
        check_eq({pfx, "_de"}, 32'(de), 32'(e_de));
        check_eq({pfx, "_hsync"}, 32'(hs), 32'((ok && hs_win(p)) ? pol : !pol));
        check_eq({pfx, "_vsync"}, 32'(vs), 32'((ok && vs_win(p)) ? pol : !pol));
    endtask

    initial begin
        int hold;
        hold = 0;
        for (int k = 0; k < N; k++) begin
            if (k < 5 || k == RST_MID) begin
                rst_h[k] = 1'b1;
            end else if (k >= 300 && k < N - 60) begin
                if (hold > 0) begin
                    rst_h[k] = 1'b1;
                    hold--;
                end else if ($urandom_range(0, 79) == 0) begin
                    rst_h[k] = 1'b1;
                    hold = int'($urandom_range(0, 2));
                end else begin
                    rst_h[k] = 1'b0;
                end
            end else begin
                rst_h[k] = 1'b0;
            end
        end

        for (int k = 0; k < N; k++) begin
            logic [11:0] ca;
            logic [23:0] cb;
            @(posedge clk);
            #1;
            cyc = k;
            pos_h[k] = (k == 0 || rst_h[k-1]) ? 0 : pos_h[k-1] + 1;
            ca = 12'($urandom);
            // First three frames: the source answers with {y,x} for the
            // request made two cycles earlier; elsewhere random data.
            if (k < RST_MID && k >= 2 && vis(pos_h[k-2]))
                ca = {4'h0, 4'((pos_h[k-2] / HT) % VT), 4'(pos_h[k-2] % HT)};
            cb = 24'($urandom);
            rst     = rst_h[k];
            color_a = ca;
            color_b = cb;
            col_h_a[k] = {12'h000, ca};
            col_h_b[k] = cb;
            #1;
            check_req("A", rv_a, rx_a, ry_a, fs_a, ls_a);
            check_req("B", rv_b, rx_b, ry_b, fs_b, ls_b);
            check_pins("A", 2, 1'b0, {12'h000, r_a, g_a, b_a}, de_a, hs_a, vs_a, 1'b0);
            check_pins("B", 1, 1'b1, {r_b, g_b, b_b}, de_b, hs_b, vs_b, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
